// File: rtl/watch_time_setter.sv
// Button-driven time editor: captures the live counter time, lets the user adjust each field,
// and emits a one-cycle set_time strobe with the packed result. Optional feature: EDIT_TIMEOUT_EN.
module watch_time_setter #(
  parameter int TIMEOUT_SEC = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk1sec,
  input  logic [7:0]  cur_year,
  input  logic [7:0]  cur_month,
  input  logic [7:0]  cur_day,
  input  logic [7:0]  cur_hour,
  input  logic [7:0]  cur_minute,
  input  logic [7:0]  cur_second,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_enter,
  input  logic        btn_cancel,
  output logic [47:0] bin_time,
  output logic        set_time,
  output logic        editing,
  output logic [2:0]  sel_field
);

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_e;

  state_e     state_q;
  logic [7:0] year_q, month_q, day_q, hour_q, minute_q, second_q;
  logic [7:0] year_d, month_d, day_d, hour_d, minute_d, second_d;
  logic [7:0] new_max;
  logic [2:0] sel_q;
  logic       set_time_q;
  logic       editing_q;

  function automatic logic is_leap(input logic [7:0] y);
    int yi;
    yi = int'(y);
    return ((yi % 4 == 0) && (yi % 100 != 0)) || (yi % 400 == 0);
  endfunction

  function automatic logic [7:0] max_date(input logic [7:0] m, input logic [7:0] y);
    case (m)
      8'd4, 8'd6, 8'd9, 8'd11: return 8'd30;
      8'd2:                    return is_leap(y) ? 8'd29 : 8'd28;
      default:                 return 8'd31;
    endcase
  endfunction

  // Out-of-range values (possible from an unchecked capture) snap to the minimum.
  function automatic logic [7:0] step_field(input logic [7:0] v, input logic [7:0] lo,
                                            input logic [7:0] hi, input logic up);
    if (v < lo || v > hi) return lo;
    if (up) return (v == hi) ? lo : v + 8'd1;
    return (v == lo) ? hi : v - 8'd1;
  endfunction

  // NOTE: every output of this block is assigned a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    year_d   = year_q;
    month_d  = month_q;
    day_d    = day_q;
    hour_d   = hour_q;
    minute_d = minute_q;
    second_d = second_q;
    new_max  = 8'd31;
    if (btn_up ^ btn_down) begin
      case (sel_q)
        3'd0: year_d   = btn_up ? year_q + 8'd1 : year_q - 8'd1;
        3'd1: month_d  = step_field(month_q, 8'd1, 8'd12, btn_up);
        3'd2: day_d    = step_field(day_q, 8'd1, max_date(month_q, year_q), btn_up);
        3'd3: hour_d   = step_field(hour_q, 8'd0, 8'd23, btn_up);
        3'd4: minute_d = step_field(minute_q, 8'd0, 8'd59, btn_up);
        3'd5: second_d = step_field(second_q, 8'd0, 8'd59, btn_up);
        default: ;
      endcase
      // A year or month change can shrink the month; pull the day back in the same update.
      new_max = max_date(month_d, year_d);
      if ((sel_q == 3'd0 || sel_q == 3'd1) && day_q > new_max) day_d = new_max;
    end
  end

`ifdef EDIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_SEC + 1);
  logic [CNT_W-1:0] idle_cnt_q;
  logic             any_btn;
  assign any_btn = btn_mode | btn_up | btn_down | btn_enter | btn_cancel;
`else
  logic unused_timeout;
  assign unused_timeout = clk1sec & (TIMEOUT_SEC != 0);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the shadow fields are individual registers, not a memory, so they take a
      // defined reset value that the counter would load on a stray strobe.
      state_q    <= S_IDLE;
      year_q     <= 8'd21;
      month_q    <= 8'd5;
      day_q      <= 8'd30;
      hour_q     <= 8'd0;
      minute_q   <= 8'd0;
      second_q   <= 8'd0;
      sel_q      <= 3'd0;
      set_time_q <= 1'b0;
      editing_q  <= 1'b0;
`ifdef EDIT_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          set_time_q <= 1'b0;
          if (btn_mode) begin
            year_q    <= cur_year;
            month_q   <= cur_month;
            day_q     <= cur_day;
            hour_q    <= cur_hour;
            minute_q  <= cur_minute;
            second_q  <= cur_second;
            sel_q     <= 3'd0;
            editing_q <= 1'b1;
            state_q   <= S_EDIT;
`ifdef EDIT_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
          end
        end
        S_EDIT: begin
          if (btn_enter) begin
            set_time_q <= 1'b1;
            editing_q  <= 1'b0;
            state_q    <= S_COMMIT;
          end else if (btn_cancel) begin
            editing_q <= 1'b0;
            state_q   <= S_IDLE;
          end else if (btn_mode) begin
            sel_q <= (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;
          end else if (btn_up | btn_down) begin
            year_q   <= year_d;
            month_q  <= month_d;
            day_q    <= day_d;
            hour_q   <= hour_d;
            minute_q <= minute_d;
            second_q <= second_d;
          end
`ifdef EDIT_TIMEOUT_EN
          else if (clk1sec) begin
            if (idle_cnt_q == CNT_W'(TIMEOUT_SEC - 1)) begin
              editing_q <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              idle_cnt_q <= idle_cnt_q + CNT_W'(1);
            end
          end
          if (any_btn) idle_cnt_q <= '0;
`endif
        end
        S_COMMIT: begin
          set_time_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          set_time_q <= 1'b0;
          editing_q  <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign bin_time  = {year_q, month_q, day_q, hour_q, minute_q, second_q};
  assign set_time  = set_time_q;
  assign editing   = editing_q;
  assign sel_field = sel_q;

endmodule

// File: tb/tb_watch_time_setter.sv
// Directed-vector bench for watch_time_setter: a table of button steps with hand-computed
// shadow/select/strobe values, plus sequences for async reset and the optional timeout.
module tb_watch_time_setter;

  localparam int TIMEOUT_SEC = 3;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_MODE = 5'b10000;
  localparam logic [4:0] B_UP   = 5'b01000;
  localparam logic [4:0] B_DN   = 5'b00100;
  localparam logic [4:0] B_EN   = 5'b00010;
  localparam logic [4:0] B_CA   = 5'b00001;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk1sec;
  logic [7:0]  cur_year, cur_month, cur_day, cur_hour, cur_minute, cur_second;
  logic        btn_mode, btn_up, btn_down, btn_enter, btn_cancel;
  logic [47:0] bin_time;
  logic        set_time;
  logic        editing;
  logic [2:0]  sel_field;

  watch_time_setter #(.TIMEOUT_SEC(TIMEOUT_SEC)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk1sec    (clk1sec),
    .cur_year   (cur_year),
    .cur_month  (cur_month),
    .cur_day    (cur_day),
    .cur_hour   (cur_hour),
    .cur_minute (cur_minute),
    .cur_second (cur_second),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_enter  (btn_enter),
    .btn_cancel (btn_cancel),
    .bin_time   (bin_time),
    .set_time   (set_time),
    .editing    (editing),
    .sel_field  (sel_field)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] cur;
    logic [4:0]  btn;
    logic [47:0] bin;
    logic [2:0]  sel;
    logic        edit;
    logic        set;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [47:0] cur, input logic [4:0] btn, input logic [47:0] bin,
                     input logic [2:0] sel, input logic edit, input logic set);
    vec_t v;
    v.cur = cur; v.btn = btn; v.bin = bin; v.sel = sel; v.edit = edit; v.set = set;
    vecs.push_back(v);
  endtask

  task automatic set_cur(input logic [47:0] c);
    {cur_year, cur_month, cur_day, cur_hour, cur_minute, cur_second} = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [4:0] b);
    {btn_mode, btn_up, btn_down, btn_enter, btn_cancel} = b;
    step();
    {btn_mode, btn_up, btn_down, btn_enter, btn_cancel} = B_NONE;
  endtask

  task automatic sec_tick();
    clk1sec = 1'b1;
    step();
    clk1sec = 1'b0;
  endtask

  localparam logic [47:0] CUR_A = 48'h16_0C_1F_17_3B_3A;  // 22/12/31 23:59:58
  localparam logic [47:0] CUR_B = 48'h14_01_1F_00_00_00;  // 20/01/31, leap
  localparam logic [47:0] CUR_C = 48'h15_01_1F_00_00_00;  // 21/01/31
  localparam logic [47:0] CUR_D = 48'h00_0D_1E_18_3C_3C;  // out-of-range month/hour/min/sec

  initial begin
    add(CUR_A, B_MODE, 48'h160C1F173B3A, 3'd0, 1'b1, 1'b0);
    add(CUR_A, B_UP,   48'h170C1F173B3A, 3'd0, 1'b1, 1'b0);
    add(CUR_A, B_EN,   48'h170C1F173B3A, 3'd0, 1'b0, 1'b1);
    add(CUR_A, B_MODE, 48'h170C1F173B3A, 3'd0, 1'b0, 1'b0);  // ignored in COMMIT
    add(CUR_A, B_UP,   48'h170C1F173B3A, 3'd0, 1'b0, 1'b0);  // ignored in IDLE
    add(CUR_B, B_MODE, 48'h14011F000000, 3'd0, 1'b1, 1'b0);
    add(CUR_B, B_MODE, 48'h14011F000000, 3'd1, 1'b1, 1'b0);
    add(CUR_B, B_UP,   48'h14021D000000, 3'd1, 1'b1, 1'b0);  // Feb leap: clamp to 29
    add(CUR_B, B_CA,   48'h14021D000000, 3'd1, 1'b0, 1'b0);
    add(CUR_C, B_MODE, 48'h15011F000000, 3'd0, 1'b1, 1'b0);
    add(CUR_C, B_MODE, 48'h15011F000000, 3'd1, 1'b1, 1'b0);
    add(CUR_C, B_UP,   48'h15021C000000, 3'd1, 1'b1, 1'b0);  // Feb non-leap: clamp to 28
    add(CUR_C, B_DN,   48'h15011C000000, 3'd1, 1'b1, 1'b0);
    add(CUR_C, B_DN,   48'h150C1C000000, 3'd1, 1'b1, 1'b0);  // month 1 -> 12
    add(CUR_C, B_MODE, 48'h150C1C000000, 3'd2, 1'b1, 1'b0);
    add(CUR_C, B_MODE, 48'h150C1C000000, 3'd3, 1'b1, 1'b0);
    add(CUR_C, B_DN,   48'h150C1C170000, 3'd3, 1'b1, 1'b0);  // hour 0 -> 23
    add(CUR_C, B_UP,   48'h150C1C000000, 3'd3, 1'b1, 1'b0);  // hour 23 -> 0
    add(CUR_C, B_MODE, 48'h150C1C000000, 3'd4, 1'b1, 1'b0);
    add(CUR_C, B_MODE, 48'h150C1C000000, 3'd5, 1'b1, 1'b0);
    add(CUR_C, B_DN,   48'h150C1C00003B, 3'd5, 1'b1, 1'b0);  // second 0 -> 59
    add(CUR_C, B_UP,   48'h150C1C000000, 3'd5, 1'b1, 1'b0);  // second 59 -> 0
    add(CUR_C, B_UP | B_DN, 48'h150C1C000000, 3'd5, 1'b1, 1'b0);
    add(CUR_C, B_MODE, 48'h150C1C000000, 3'd0, 1'b1, 1'b0);  // select 5 -> 0
    add(CUR_C, B_DN,   48'h140C1C000000, 3'd0, 1'b1, 1'b0);
    add(CUR_C, B_EN | B_CA, 48'h140C1C000000, 3'd0, 1'b0, 1'b1);
    add(CUR_C, B_NONE, 48'h140C1C000000, 3'd0, 1'b0, 1'b0);
    add(CUR_D, B_MODE, 48'h000D1E183C3C, 3'd0, 1'b1, 1'b0);
    add(CUR_D, B_MODE, 48'h000D1E183C3C, 3'd1, 1'b1, 1'b0);
    add(CUR_D, B_UP,   48'h00011E183C3C, 3'd1, 1'b1, 1'b0);  // month 13 -> min
    add(CUR_D, B_MODE, 48'h00011E183C3C, 3'd2, 1'b1, 1'b0);
    add(CUR_D, B_DN,   48'h00011D183C3C, 3'd2, 1'b1, 1'b0);
    add(CUR_D, B_MODE, 48'h00011D183C3C, 3'd3, 1'b1, 1'b0);
    add(CUR_D, B_DN,   48'h00011D003C3C, 3'd3, 1'b1, 1'b0);  // hour 24 -> min
    add(CUR_D, B_MODE, 48'h00011D003C3C, 3'd4, 1'b1, 1'b0);
    add(CUR_D, B_UP,   48'h00011D00003C, 3'd4, 1'b1, 1'b0);  // minute 60 -> min
    add(CUR_D, B_MODE, 48'h00011D00003C, 3'd5, 1'b1, 1'b0);
    add(CUR_D, B_MODE, 48'h00011D00003C, 3'd0, 1'b1, 1'b0);
    add(CUR_D, B_DN,   48'hFF011D00003C, 3'd0, 1'b1, 1'b0);  // year 0 -> 255
    add(CUR_D, B_MODE, 48'hFF011D00003C, 3'd1, 1'b1, 1'b0);
    add(CUR_D, B_DN,   48'hFF0C1D00003C, 3'd1, 1'b1, 1'b0);
    add(CUR_D, B_UP,   48'hFF011D00003C, 3'd1, 1'b1, 1'b0);  // month 12 -> 1
    add(CUR_D, B_UP,   48'hFF021C00003C, 3'd1, 1'b1, 1'b0);  // 255 not leap: clamp 28
    add(CUR_D, B_MODE, 48'hFF021C00003C, 3'd2, 1'b1, 1'b0);
    add(CUR_D, B_UP,   48'hFF020100003C, 3'd2, 1'b1, 1'b0);  // day 28 (max) -> 1
    add(CUR_D, B_CA,   48'hFF020100003C, 3'd2, 1'b0, 1'b0);

    rst = 1'b0;
    clk1sec = 1'b0;
    {btn_mode, btn_up, btn_down, btn_enter, btn_cancel} = B_NONE;
    set_cur(CUR_A);
    #12;
    check("reset bin_time", bin_time, 48'h15051E000000);
    check("reset set_time", 48'(set_time), 48'd0);
    check("reset editing", 48'(editing), 48'd0);
    check("reset sel_field", 48'(sel_field), 48'd0);
    step();
    rst = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      set_cur(vecs[i].cur);
      apply(vecs[i].btn);
      check($sformatf("v%0d bin_time", i), bin_time, vecs[i].bin);
      check($sformatf("v%0d sel_field", i), 48'(sel_field), 48'(vecs[i].sel));
      check($sformatf("v%0d editing", i), 48'(editing), 48'(vecs[i].edit));
      check($sformatf("v%0d set_time", i), 48'(set_time), 48'(vecs[i].set));
    end

    // Asynchronous reset in the middle of an edit, with enter held while in reset.
    set_cur(CUR_A);
    apply(B_MODE);
    apply(B_UP);
    check("pre-areset bin_time", bin_time, 48'h170C1F173B3A);
    #3;
    rst = 1'b0;
    #1;
    check("areset bin_time", bin_time, 48'h15051E000000);
    check("areset editing", 48'(editing), 48'd0);
    check("areset sel_field", 48'(sel_field), 48'd0);
    btn_enter = 1'b1;
    step();
    btn_enter = 1'b0;
    check("areset set_time", 48'(set_time), 48'd0);
    rst = 1'b1;
    step();
    check("post-areset set_time", 48'(set_time), 48'd0);
    check("post-areset editing", 48'(editing), 48'd0);

`ifdef EDIT_TIMEOUT_EN
    // Three idle ticks abandon the edit with no strobe.
    set_cur(CUR_C);
    apply(B_MODE);
    check("to editing", 48'(editing), 48'd1);
    for (int t = 1; t <= TIMEOUT_SEC; t++) begin
      sec_tick();
      check($sformatf("to tick%0d set_time", t), 48'(set_time), 48'd0);
      check($sformatf("to tick%0d editing", t), 48'(editing), 48'(t < TIMEOUT_SEC));
      step();
      check($sformatf("to gap%0d set_time", t), 48'(set_time), 48'd0);
    end
    check("to bin_time held", bin_time, CUR_C);

    // A button between ticks 2 and 3 restarts the count.
    apply(B_MODE);
    sec_tick();
    sec_tick();
    apply(B_UP);
    sec_tick();
    check("to restart editing", 48'(editing), 48'd1);
    sec_tick();
    sec_tick();
    check("to restart expiry editing", 48'(editing), 48'd0);
    check("to restart set_time", 48'(set_time), 48'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
